// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared FSM state type and default parameters for the UART transmit arbiter
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DATA_W         = 8;
   localparam int DEF_MAX_BURST      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals of the UART transmit arbiter
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W
) ();

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*DATA_W-1:0]   req_data;
   logic [NUM_REQ-1:0]          req_last;
   logic [NUM_REQ-1:0]          req_ready;
   logic                        tx_start;
   logic [DATA_W-1:0]           tx_data;
   logic                        tx_busy;
   logic [$clog2(NUM_REQ)-1:0]  grant_id;
   logic                        grant_active;
   logic                        err_timeout;

   modport master (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout
   );

   modport slave (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request after ptr, wrapping to 0
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx,
   output logic               any
);

   always_comb begin
      int k;
      k     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // Walk from farthest to nearest so the slot right after ptr wins last.
      for (int i = NUM_REQ; i >= 1; i--) begin
         k = (int'(ptr) + i) % NUM_REQ;
         if (req[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            idx      = IW'(k);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding one UART transmitter
// Optional busy-rise watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int MAX_BURST      = DEF_MAX_BURST,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               RSTn,
   uart_tx_arbiter_if.master  bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

   arb_state_t          state;
   logic [NUM_REQ-1:0]  ready_q;
   logic [NUM_REQ-1:0]  gnt_oh_q;
   logic                start_q;
   logic [DATA_W-1:0]   data_q;
   logic [IW-1:0]       gid_q;
   logic                active_q;
   logic                last_q;
   logic                err_q;
   logic [BW-1:0]       burst_q;
   logic [IW-1:0]       winner_q;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]       to_cnt;
`else
   assign err_q = 1'b0;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (winner_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state    <= IDLE;
         ready_q  <= '0;
         gnt_oh_q <= '0;
         start_q  <= 1'b0;
         data_q   <= '0;
         gid_q    <= '0;
         active_q <= 1'b0;
         last_q   <= 1'b0;
         burst_q  <= '0;
         winner_q <= IW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
         err_q    <= 1'b0;
         to_cnt   <= '0;
`endif
      end else begin
         ready_q <= '0;
         start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (arb_any) begin
                  gid_q    <= arb_idx;
                  gnt_oh_q <= arb_grant;
                  active_q <= 1'b1;
                  burst_q  <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               // Byte is consumed here; a later reset must not replay it.
               ready_q <= gnt_oh_q;
               start_q <= 1'b1;
               data_q  <= bus.req_data[gid_q*DATA_W +: DATA_W];
               last_q  <= bus.req_last[gid_q];
               burst_q <= burst_q + 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
               to_cnt  <= '0;
`endif
               state   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state <= WAIT_DONE;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  err_q    <= 1'b1;
                  active_q <= 1'b0;
                  winner_q <= gid_q;
                  state    <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  if (bus.req_valid[gid_q] && !last_q && (burst_q < BURST_LIM)) begin
                     state <= LOAD;
                  end else begin
                     active_q <= 1'b0;
                     winner_q <= gid_q;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.tx_start     = start_q;
   assign bus.tx_data      = data_q;
   assign bus.grant_id     = gid_q;
   assign bus.grant_active = active_q;
   assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with queue-based requesters
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
      .clk  (clk),
      .RSTn (rstn),
      .bus  (bus)
   );

   typedef struct {
      int            id;
      logic [7:0]    d;
      logic [NR-1:0] rdy;
   } ev_t;

   int checks = 0;
   int failures = 0;
   logic [8:0] rq [NR][$];
   logic [8:0] mq [NR][$];
   ev_t obs[$];
   ev_t expq[$];
   bit tx_mute = 1'b0;
   int d_cnt = 0;
   int f_cnt = 0;

   // Requesters pop on req_ready; transmitter raises busy after a random delay.
   always @(negedge clk) begin
      if (!rstn) begin
         bus.tx_busy = 1'b0;
         d_cnt = 0;
         f_cnt = 0;
      end else begin
         for (int i = 0; i < NR; i++)
            if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (bus.tx_start && !tx_mute) begin
            d_cnt = $urandom_range(0, 2);
            f_cnt = $urandom_range(1, 4);
         end else if (d_cnt > 0) begin
            d_cnt--;
         end else if (f_cnt > 0) begin
            bus.tx_busy = 1'b1;
            f_cnt--;
         end else begin
            bus.tx_busy = 1'b0;
         end
      end
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i]         = rq[i].size() > 0;
         bus.req_last[i]          = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
         bus.req_data[i*DW +: DW] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      end
   end

   always @(negedge clk)
      if (rstn && bus.tx_start)
         obs.push_back('{int'(bus.grant_id), bus.tx_data, bus.req_ready});

   task automatic do_reset();
      rstn = 1'b0;
      tx_mute = 1'b0;
      for (int i = 0; i < NR; i++) rq[i].delete();
      repeat (2) @(negedge clk);
      obs.delete();
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic push(int r, logic [7:0] d, bit last);
      rq[r].push_back({last, d});
      mq[r].push_back({last, d});
   endtask

   task automatic wait_obs(int n, int budget, string name);
      int c = 0;
      while (obs.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (obs.size() < n) begin
         failures++;
         $display("FAIL %s_count: got %0d tx_start pulses, expected %0d", name, obs.size(), n);
      end
   endtask

   task automatic wait_idle(int budget, string name);
      int c = 0;
      while (bus.grant_active && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (bus.grant_active !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle: grant_active still 1 after %0d cycles", name, budget);
      end
   endtask

   // Transaction-level reference: serve packets round-robin, at most MB bytes per grant.
   task automatic build_model();
      int last = NR - 1;
      expq.delete();
      while (1) begin
         int sel = -1;
         int cnt = 0;
         logic [8:0] e;
         for (int s = 1; s <= NR; s++)
            if (sel < 0 && mq[(last + s) % NR].size() > 0) sel = (last + s) % NR;
         if (sel < 0) break;
         do begin
            e = mq[sel].pop_front();
            expq.push_back('{sel, e[7:0], NR'(1) << sel});
            cnt++;
         end while (!e[8] && cnt < MB && mq[sel].size() > 0);
         last = sel;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.req_ready !== '0)   begin failures++; $display("FAIL rst_ready: got %b expected 0", bus.req_ready); end
      checks++; if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL rst_start: got %b expected 0", bus.tx_start); end
      checks++; if (bus.tx_data !== 8'h00)  begin failures++; $display("FAIL rst_data: got %h expected 00", bus.tx_data); end
      checks++; if (bus.grant_id !== 2'd0)  begin failures++; $display("FAIL rst_gid: got %0d expected 0", bus.grant_id); end
      checks++; if (bus.grant_active !== 1'b0) begin failures++; $display("FAIL rst_active: got %b expected 0", bus.grant_active); end
      checks++; if (bus.err_timeout !== 1'b0)  begin failures++; $display("FAIL rst_err: got %b expected 0", bus.err_timeout); end
   endtask

   task automatic test_single();
      do_reset();
      push(1, 8'hA5, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start: got %b expected 0", bus.tx_start); end
      checks++; if (bus.grant_id !== 2'd1) begin failures++; $display("FAIL single_gid: got %0d expected 1", bus.grant_id); end
      checks++; if (bus.grant_active !== 1'b1) begin failures++; $display("FAIL single_active: got %b expected 1", bus.grant_active); end
      @(negedge clk);
      checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b expected 1", bus.tx_start); end
      checks++; if (bus.tx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", bus.tx_data); end
      checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b expected 0010", bus.req_ready); end
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) begin
         failures++; $display("FAIL single_pulse_len: ready=%b start=%b expected 0000/0", bus.req_ready, bus.tx_start);
      end
      wait_idle(40, "single");
   endtask

   task automatic test_rr_order();
      int exp_id[$] = '{0, 1, 2, 3, 0};
      int exp_d[$]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      do_reset();
      push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1);
      push(3, 8'h13, 1'b1); push(0, 8'h14, 1'b1);
      wait_obs(5, 200, "rr");
      for (int i = 0; i < 5; i++) if (i < obs.size()) begin
         checks++;
         if (obs[i].id !== exp_id[i] || obs[i].d !== exp_d[i][7:0]) begin
            failures++; $display("FAIL rr_order[%0d]: got id=%0d data=%h expected id=%0d data=%h", i, obs[i].id, obs[i].d, exp_id[i], exp_d[i]);
         end
      end
      wait_idle(40, "rr");
   endtask

   task automatic test_burst();
      int exp_id[$] = '{2, 2, 2, 2, 3, 2, 2};
      int exp_d[$]  = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h24, 8'h25};
      do_reset();
      for (int b = 0; b < 6; b++) push(2, 8'(8'h20 + b), 1'b0);
      push(3, 8'h30, 1'b1);
      wait_obs(7, 300, "burst");
      for (int i = 0; i < 7; i++) if (i < obs.size()) begin
         checks++;
         if (obs[i].id !== exp_id[i] || obs[i].d !== exp_d[i][7:0]) begin
            failures++; $display("FAIL burst_order[%0d]: got id=%0d data=%h expected id=%0d data=%h", i, obs[i].id, obs[i].d, exp_id[i], exp_d[i]);
         end
      end
      wait_idle(40, "burst");
   endtask

   task automatic test_last();
      int exp_id[$] = '{0, 0, 1, 0, 0};
      int exp_d[$]  = '{8'h40, 8'h41, 8'h50, 8'h42, 8'h43};
      do_reset();
      push(0, 8'h40, 1'b0); push(0, 8'h41, 1'b1); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
      push(1, 8'h50, 1'b1);
      wait_obs(5, 200, "last");
      for (int i = 0; i < 5; i++) if (i < obs.size()) begin
         checks++;
         if (obs[i].id !== exp_id[i] || obs[i].d !== exp_d[i][7:0]) begin
            failures++; $display("FAIL last_order[%0d]: got id=%0d data=%h expected id=%0d data=%h", i, obs[i].id, obs[i].d, exp_id[i], exp_d[i]);
         end
      end
      wait_idle(40, "last");
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      tx_mute = 1'b1;
      push(0, 8'h77, 1'b1);
      while (!bus.tx_start && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL to_start: got %b expected 1", bus.tx_start); end
      n = 0;
`ifdef UART_ARB_TIMEOUT_EN
      while (!bus.err_timeout && n < 40) begin @(negedge clk); n++; end
      checks++; if (n != TO) begin failures++; $display("FAIL to_cycles: got %0d expected %0d", n, TO); end
      checks++; if (bus.grant_active !== 1'b0) begin failures++; $display("FAIL to_release: got %b expected 0", bus.grant_active); end
      @(negedge clk);
      checks++; if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL to_pulse: got %b expected 0", bus.err_timeout); end
`else
      repeat (40) @(negedge clk);
      checks++; if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL to_off_err: got %b expected 0", bus.err_timeout); end
      checks++; if (bus.grant_active !== 1'b1 || bus.tx_start !== 1'b0) begin
         failures++; $display("FAIL to_off_hold: active=%b start=%b expected 1/0", bus.grant_active, bus.tx_start);
      end
`endif
      tx_mute = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      push(1, 8'h5A, 1'b0); push(1, 8'h5B, 1'b1);
      while (!bus.tx_busy && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #2;
      checks++; if (bus.grant_active !== 1'b1 || bus.tx_data !== 8'h5A) begin
         failures++; $display("FAIL mid_pre: active=%b data=%h expected 1/5a", bus.grant_active, bus.tx_data);
      end
      rstn = 1'b0;
      #1;
      checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h expected 00", bus.tx_data); end
      checks++; if (bus.grant_active !== 1'b0 || bus.grant_id !== 2'd0) begin
         failures++; $display("FAIL mid_grant: active=%b gid=%0d expected 0/0", bus.grant_active, bus.grant_id);
      end
      checks++; if (bus.tx_start !== 1'b0 || bus.req_ready !== '0 || bus.err_timeout !== 1'b0) begin
         failures++; $display("FAIL mid_pulses: start=%b ready=%b err=%b expected 0", bus.tx_start, bus.req_ready, bus.err_timeout);
      end
      for (int i = 0; i < NR; i++) rq[i].delete();
      push(1, 8'h61, 1'b1); push(0, 8'h60, 1'b1);
      repeat (2) @(negedge clk);
      obs.delete();
      rstn = 1'b1;
      wait_obs(2, 100, "mid");
      if (obs.size() >= 2) begin
         checks++;
         if (obs[0].id !== 0 || obs[1].id !== 1) begin
            failures++; $display("FAIL mid_order: got %0d,%0d expected 0,1", obs[0].id, obs[1].id);
         end
      end
      wait_idle(40, "mid");
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         do_reset();
         for (int r = 0; r < NR; r++) mq[r].delete();
         for (int r = 0; r < NR; r++) begin
            int len = $urandom_range(0, 6);
            for (int b = 0; b < len; b++) push(r, 8'($urandom), $urandom_range(0, 2) == 0);
         end
         build_model();
         wait_obs(expq.size(), 20 * expq.size() + 50, "rand");
         for (int i = 0; i < expq.size(); i++) if (i < obs.size()) begin
            checks++;
            if (obs[i].id !== expq[i].id || obs[i].d !== expq[i].d || obs[i].rdy !== expq[i].rdy) begin
               failures++;
               $display("FAIL rand%0d[%0d]: got id=%0d data=%h ready=%b expected id=%0d data=%h ready=%b",
                        it, i, obs[i].id, obs[i].d, obs[i].rdy, expq[i].id, expq[i].d, expq[i].rdy);
            end
         end
         wait_idle(40, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_order();
      test_burst();
      test_last();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum bytes per grant before rotation (1..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, busy-rise watchdog limit (used only under UART_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester byte, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_last  input  NUM_REQ  byte is last of the requester's packet.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot byte-accept pulse.
REQ-011 SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-012 SHALL have port tx_data  output  DATA_W  registered byte to the transmitter.
REQ-013 SHALL have port tx_busy  input  1  transmitter frame in progress.
REQ-014 SHALL have port grant_id  output  $clog2(NUM_REQ)  current or last owner index.
REQ-015 SHALL have port grant_active  output  1  a requester owns the transmitter.
REQ-016 SHALL have port err_timeout  output  1  one-cycle watchdog pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-018 SHALL, in IDLE with any req_valid high, select the first valid requester scanning from (last_winner+1) mod NUM_REQ, register it as grant_id, set grant_active, clear burst count, and enter LOAD next cycle.
REQ-019 SHALL, in LOAD, assert req_ready[grant_id] and tx_start for exactly one cycle, register req_data of grant_id into tx_data, latch req_last, increment burst count, and enter WAIT_BUSY.
REQ-020 SHALL, in WAIT_BUSY, hold tx_data stable and enter WAIT_DONE on the first cycle tx_busy=1.
REQ-021 SHALL, in WAIT_DONE on tx_busy=0, return to LOAD if req_valid[grant_id]=1, latched last=0 and burst count<MAX_BURST; otherwise clear grant_active, set last_winner=grant_id, and enter IDLE.
REQ-022 SHALL give minimum latency from req_valid rise (IDLE) to tx_start of 2 cycles.
REQ-023 SHALL never assert req_ready or tx_start outside LOAD; req_ready SHALL be zero or one-hot.
REQ-024 SHALL ignore req_valid changes of non-granted requesters while grant_active=1.
REQ-025 SHALL, if req_valid[grant_id] drops mid-burst, end the grant at the next WAIT_DONE exit (no packet hold).
REQ-026 SHALL wrap the round-robin pointer from NUM_REQ-1 to 0.
REQ-027 SHALL size burst count to hold MAX_BURST without overflow.

Reset
REQ-028 SHALL, on RSTn=0, asynchronously force state IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, err_timeout=0, burst count=0, and last_winner=NUM_REQ-1 so requester 0 has first priority.
REQ-029 SHALL, on reset mid-transfer, abandon the byte without re-issuing it after reset.

Configuration
REQ-030 SHALL, with UART_ARB_TIMEOUT_EN defined, count cycles in WAIT_BUSY and, on reaching TIMEOUT_CYCLES without tx_busy, pulse err_timeout one cycle, release the grant (last_winner=grant_id), and enter IDLE.
REQ-031 SHALL, without UART_ARB_TIMEOUT_EN, wait indefinitely in WAIT_BUSY and tie err_timeout to 0.

Structure
REQ-032 SHALL place the state enum typedef and the default parameter constants in package uart_arb_pkg.
REQ-033 SHALL use one sub-module rr_arbiter (request vector plus pointer in, one-hot grant plus index out), combinational.

Verification
REQ-034 SHALL cover single requester: req_valid=4'b0010, data 8'hA5, last=1 -> tx_start 2 cycles later, tx_data=8'hA5, req_ready=4'b0010 one cycle, grant_id=1.
REQ-035 SHALL cover all four valid from reset, each sending 1-byte packets -> grant order 0,1,2,3,0.
REQ-036 SHALL cover requester 2 streaming 6 bytes with last=0, MAX_BURST=4 and requester 3 valid -> 4 bytes from 2, then 3 granted, then 2 resumes.
REQ-037 SHALL cover req_last on byte 2 of requester 0 while requester 0 stays valid -> grant released after byte 2 and next valid requester served.
REQ-038 SHALL cover tx_busy held 0 after tx_start with macro on, TIMEOUT_CYCLES=16 -> err_timeout pulse after 16 WAIT_BUSY cycles, then IDLE; with macro off, state remains WAIT_BUSY.
REQ-039 SHALL cover RSTn low during WAIT_DONE -> all outputs 0 immediately (asynchronous) and requester 0 granted first after release.
